// File: rtl/xilly_upstream_arbiter.sv
// Round-robin arbiter that shares one upstream Xillybus stream FIFO between N_REQ producers.
// Define XILLY_ARB_HEADER_EN to prefix each burst with a one-word source header (HDR state).
module xilly_upstream_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 64,
    parameter int SRC_W     = 2
) (
    input  logic                      bus_clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      stream_open,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          led
);

    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam int                LED_W     = 20;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [LED_W-1:0]  LED_LOAD  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_BURST
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [SRC_W-1:0]    r_grant_idx;
    logic [SRC_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [LED_W-1:0]    r_led_cnt [N_REQ];

    logic [SRC_W-1:0]    w_pick_idx;
    logic                w_pick_found;
    logic                w_start;
    logic                w_path_open;
    logic                w_valid_g;
    logic                w_last_g;
    logic [DATA_W-1:0]   w_data_g;
    logic [N_REQ-1:0]    w_grant_oh;
    logic                w_accept;
    logic                w_eob;
    logic                w_leave;
    logic [SRC_W-1:0]    w_next_ptr;

    // Search upward from the round-robin pointer, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_pick_found && req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = SRC_W'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_start     = (r_state == S_IDLE) && stream_open && w_pick_found;
    assign w_path_open = stream_open & ~fifo_full;
    assign w_valid_g   = req_valid[r_grant_idx];
    assign w_last_g    = req_last[r_grant_idx];
    assign w_data_g    = req_data[int'(r_grant_idx) * DATA_W +: DATA_W];
    assign w_grant_oh  = N_REQ'(1) << r_grant_idx;
    assign w_accept    = (r_state == S_BURST) & w_path_open & w_valid_g;
    assign w_eob       = w_accept & (w_last_g | (r_beat_cnt == LAST_BEAT));
    // A close wins over end-of-burst: w_accept is already 0 when stream_open is low.
    assign w_leave     = (r_state != S_IDLE) & (~stream_open | w_eob);
    assign w_next_ptr  = (r_grant_idx == SRC_W'(N_REQ - 1)) ? '0 : r_grant_idx + SRC_W'(1);

`ifdef XILLY_ARB_HEADER_EN
    logic [DATA_W-1:0] w_hdr_word;
    assign w_hdr_word = {8'hA5, {(DATA_W - 8){1'b0}}} | DATA_W'(r_grant_idx);
`endif

    // State register.
    always_ff @(posedge bus_clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
`ifdef XILLY_ARB_HEADER_EN
                    w_next_state = S_HDR;
`else
                    w_next_state = S_BURST;
`endif
                end
            end
`ifdef XILLY_ARB_HEADER_EN
            S_HDR: begin
                if (!stream_open) begin
                    w_next_state = S_IDLE;
                end else if (!fifo_full) begin
                    w_next_state = S_BURST;
                end
            end
`endif
            S_BURST: begin
                if (w_leave) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: the ready and write paths stay combinational for zero-latency backpressure.
    always_comb begin
        grant      = '0;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_data  = '0;
        case (r_state)
`ifdef XILLY_ARB_HEADER_EN
            S_HDR: begin
                grant      = w_grant_oh;
                fifo_wr_en = w_path_open;
                fifo_data  = w_hdr_word;
            end
`endif
            S_BURST: begin
                grant                  = w_grant_oh;
                req_ready[r_grant_idx] = w_path_open;
                fifo_wr_en             = w_accept;
                fifo_data              = w_data_g;
            end
            default: begin
                grant = '0;
            end
        endcase
    end

    // Grant index, round-robin pointer and beat counter.
    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_start) begin
                r_grant_idx <= w_pick_idx;
            end
            if (w_leave) begin
                r_rr_ptr   <= w_next_ptr;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
        end
    end

    // Per-requester activity stretch for the board LEDs.
    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_led_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept && (r_grant_idx == SRC_W'(i))) begin
                    r_led_cnt[i] <= LED_LOAD;
                end else if (r_led_cnt[i] != '0) begin
                    r_led_cnt[i] <= r_led_cnt[i] - LED_W'(1);
                end
            end
        end
    end

    always_comb begin
        led = '0;
        for (int i = 0; i < N_REQ; i++) begin
            led[i] = (r_led_cnt[i] != '0);
        end
    end

endmodule
